// File: rtl/snn_spike_delay_bank_if.sv
// Delay-configuration handshake (valid/ready) between a controller and snn_spike_delay_bank.
interface snn_spike_delay_bank_if #(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned MAX_DELAY = 8
);
    localparam int unsigned DW = $clog2(MAX_DELAY);
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_delay;

    modport master (output cfg_valid, output cfg_ch, output cfg_delay, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_delay, output cfg_ready);
endinterface

// File: rtl/snn_spike_delay_bank.sv
// Per-channel programmable spike delay lines with config handshake, timed flush and
// an optional saturating output spike counter (enabled by macro SNN_SPIKE_COUNT_EN).
module snn_spike_delay_bank #(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned MAX_DELAY = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [N_CH-1:0]          spike_in,
    output logic [N_CH-1:0]          spike_out,
    input  logic                     flush,
    output logic [CNT_W-1:0]         spike_cnt,
    snn_spike_delay_bank_if.slave    cfg
);
    localparam int unsigned DW = $clog2(MAX_DELAY);
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned LW = MAX_DELAY - 1;
    localparam logic [DW-1:0] DLY_MAX = DW'(MAX_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   fcnt_q, fcnt_d;
    logic [CW-1:0]   ach_q, ach_d;
    logic [DW-1:0]   dly_q  [N_CH];
    logic [DW-1:0]   dly_d  [N_CH];
    logic [LW-1:0]   line_q [N_CH];
    logic [LW-1:0]   line_d [N_CH];
    logic [MAX_DELAY-1:0] tap_c [N_CH];
    logic [N_CH-1:0] spike_out_q, spike_out_d;
    logic            cfg_fire_c;
    logic            cfg_ch_ok_c;
    logic [DW-1:0]   cfg_dly_clamp_c;

    // Flush requests take priority: the bank refuses config in the same cycle.
    assign cfg.cfg_ready   = (state_q == S_IDLE) && !flush;
    assign cfg_fire_c      = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_ch_ok_c     = (32'(cfg.cfg_ch) < N_CH);
    assign cfg_dly_clamp_c = (cfg.cfg_delay > DLY_MAX) ? DLY_MAX : cfg.cfg_delay;

    // Tap 0 is the live input, tap j is the spike sampled j enabled edges ago.
    for (genvar g = 0; g < N_CH; g++) begin : g_tap
        assign tap_c[g] = {line_q[g], spike_in[g]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            ach_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            ach_q   <= ach_d;
        end
    end

    // Control FSM: flush counter runs on every edge regardless of ena.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        ach_d   = ach_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end else if (cfg_fire_c) begin
                    state_d = S_APPLY;
                    ach_d   = cfg.cfg_ch;
                end
            end
            S_APPLY: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (flush) begin
                    fcnt_d = '0;
                end else if (fcnt_q == DLY_MAX) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_out_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                line_q[c] <= '0;
                dly_q[c]  <= '0;
            end
        end else begin
            spike_out_q <= spike_out_d;
            for (int c = 0; c < N_CH; c++) begin
                line_q[c] <= line_d[c];
                dly_q[c]  <= dly_d[c];
            end
        end
    end

    // Datapath: shift, tap select, and the per-state clears.
    always_comb begin
        spike_out_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            line_d[c] = line_q[c];
            dly_d[c]  = dly_q[c];
        end
        if (cfg_fire_c && cfg_ch_ok_c) begin
            dly_d[cfg.cfg_ch] = cfg_dly_clamp_c;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (state_q == S_FLUSH) begin
                line_d[c] = '0;
            end else begin
                if (ena) begin
                    line_d[c]      = LW'({line_q[c], spike_in[c]});
                    spike_out_d[c] = tap_c[c][dly_q[c]];
                end
                if ((state_q == S_APPLY) && (ach_q == CW'(c))) begin
                    line_d[c]      = '0;
                    spike_out_d[c] = 1'b0;
                end
            end
        end
    end

    assign spike_out = spike_out_q;

`ifdef SNN_SPIKE_COUNT_EN
    localparam int unsigned PW = $clog2(N_CH + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pop_c;
    logic [SW-1:0]    sum_c;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop_c = pop_c + PW'(spike_out_q[i]);
        end
    end

    // Saturating accumulate of the registered output; FLUSH clears it.
    always_comb begin
        sum_c = SW'(cnt_q) + SW'(pop_c);
        cnt_d = (sum_c > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_c);
        if (state_q == S_FLUSH) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_cnt = cnt_q;
`else
    assign spike_cnt = '0;
`endif

endmodule
